// File: rtl/m_ex_mem_skid_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// readyE is registered, so there is no combinational path from readyM back to EX.
module m_ex_mem_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               validE,
  output logic               readyE,
  input  logic [CTRL_W-1:0]  ctrlE,
  input  logic [DATA_W-1:0]  aluoutE,
  input  logic [DATA_W-1:0]  writedataE,
  input  logic [REG_W-1:0]   writeregE,
  input  logic [INSTR_W-1:0] instrE,
  output logic               validM,
  input  logic               readyM,
  output logic [CTRL_W-1:0]  ctrlM,
  output logic [DATA_W-1:0]  aluoutM,
  output logic [DATA_W-1:0]  writedataM,
  output logic [REG_W-1:0]   writeregM,
  output logic [INSTR_W-1:0] instrM,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [1:0]         dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1;
  // EX side uses validE/readyE, MEM side uses validM/readyM.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  aluout;
    logic [DATA_W-1:0]  writedata;
    logic [REG_W-1:0]   writereg;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_e;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept;
  logic             drain;

  assign new_e  = '{ctrl: ctrlE, aluout: aluoutE, writedata: writedataE,
                    writereg: writeregE, instr: instrE};
  assign accept = validE & ready_q;
  assign drain  = (state_q != ST_EMPTY) & readyM;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_e;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = new_e;
        end else if (accept) begin
          skid_d  = new_e;
          state_d = ST_TWO;
        end else if (drain) begin
          // Bubble: keep data, but never leave a live regwrite/memwrite behind.
          main_d.ctrl = '0;
          state_d     = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          main_d      = skid_q;
          skid_d.ctrl = '0;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush wins over any concurrent accept or drain.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_d      = main_q;
      skid_d      = skid_q;
      main_d.ctrl = '0;
      skid_d.ctrl = '0;
    end

    ready_d = (state_d != ST_TWO);

    if ((state_q != ST_EMPTY) && !readyM && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      stall_q <= stall_d;
    end
  end

  assign readyE     = ready_q;
  assign validM     = (state_q != ST_EMPTY);
  assign ctrlM      = main_q.ctrl;
  assign aluoutM    = main_q.aluout;
  assign writedataM = main_q.writedata;
  assign writeregM  = main_q.writereg;
  assign instrM     = main_q.instr;
  assign stall_cnt  = stall_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_m_ex_mem_skid_reg.sv
// Directed vector table, corner-case sequences and a random scoreboard run
// for m_ex_mem_skid_reg (default widths, plus a CNT_W=4 copy for saturation).
module tb_m_ex_mem_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        validE;
  logic        readyM;
  logic [2:0]  ctrlE;
  logic [31:0] aluoutE, writedataE, instrE;
  logic [4:0]  writeregE;

  logic        readyE, validM;
  logic [2:0]  ctrlM;
  logic [31:0] aluoutM, writedataM, instrM;
  logic [4:0]  writeregM;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  logic        readyE4, validM4;
  logic [2:0]  ctrlM4;
  logic [31:0] aluoutM4, writedataM4, instrM4;
  logic [4:0]  writeregM4;
  logic [3:0]  stall_cnt4;
  logic [1:0]  dbg_state4;

  int pass_cnt = 0;
  int total_cnt = 0;

  m_ex_mem_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .validE(validE), .readyE(readyE),
    .ctrlE(ctrlE), .aluoutE(aluoutE), .writedataE(writedataE),
    .writeregE(writeregE), .instrE(instrE), .validM(validM), .readyM(readyM),
    .ctrlM(ctrlM), .aluoutM(aluoutM), .writedataM(writedataM),
    .writeregM(writeregM), .instrM(instrM), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  m_ex_mem_skid_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .validE(validE), .readyE(readyE4),
    .ctrlE(ctrlE), .aluoutE(aluoutE), .writedataE(writedataE),
    .writeregE(writeregE), .instrE(instrE), .validM(validM4), .readyM(readyM),
    .ctrlM(ctrlM4), .aluoutM(aluoutM4), .writedataM(writedataM4),
    .writeregM(writeregM4), .instrM(instrM4), .stall_cnt(stall_cnt4),
    .dbg_state(dbg_state4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // payload fields derived from the instruction word; all zero for instr 0
  function automatic logic [31:0] alu_of(input logic [31:0] i);
    return i * 32'd3;
  endfunction
  function automatic logic [31:0] wd_of(input logic [31:0] i);
    return {i[15:0], i[31:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // driver
  task automatic drive(input logic r, input logic f, input logic v, input logic rm,
                       input logic [31:0] ins, input logic [2:0] c);
    rst_n      = r;
    flush      = f;
    validE     = v;
    readyM     = rm;
    instrE     = ins;
    ctrlE      = c;
    aluoutE    = alu_of(ins);
    writedataE = wd_of(ins);
    writeregE  = ins[4:0];
  endtask

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        valid_e;
    logic        ready_m;
    logic [31:0] instr_e;
    logic [2:0]  ctrl_e;
    logic        exp_valid_m;
    logic        exp_ready_e;
    logic [31:0] exp_instr_m;
    logic [2:0]  exp_ctrl_m;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic v, input logic rm,
                     input logic [31:0] ins, input logic [2:0] c,
                     input logic ev, input logic er, input logic [31:0] ei,
                     input logic [2:0] ec, input logic [15:0] es);
    vec_t t;
    t = '{r, f, v, rm, ins, c, ev, er, ei, ec, es};
    vecs.push_back(t);
  endtask

  // scoreboard: {ctrl, instr} of accepted beats in order
  logic [34:0] exp_q[$];
  int          occ = 0;

  task automatic rand_step(input logic v, input logic rm);
    logic [31:0] ins;
    logic [2:0]  c;
    logic [34:0] head;
    check("rnd_validM", validM, occ > 0);
    check("rnd_readyE", readyE, occ < 2);
    if (occ == 0) check("rnd_bubble_ctrl", ctrlM, 3'b000);
    ins = $urandom;
    c   = 3'($urandom_range(0, 7));
    drive(1'b1, 1'b0, v, rm, ins, c);
    if (occ > 0 && rm) begin
      head = exp_q.pop_front();
      check("rnd_instrM", instrM, head[31:0]);
      check("rnd_ctrlM", ctrlM, head[34:32]);
      check("rnd_aluoutM", aluoutM, alu_of(head[31:0]));
      occ--;
    end
    if (v && (exp_q.size() + ((occ > 0 && rm) ? 0 : 0)) < 2 && readyE_model_ok()) begin
      exp_q.push_back({c, ins});
    end
    occ = exp_q.size();
  endtask

  // readiness before this edge is set by occupancy after the previous edge
  int occ_prev = 0;
  function automatic bit readyE_model_ok();
    return occ_prev < 2;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);

    //    rst flush vE rdyM instrE       ctrlE   vM rdyE instrM       ctrlM  stall
    add(0, 0, 0, 0, 32'h0,  3'b000,  0, 1, 32'h0,  3'b000, 16'd0); // reset
    add(1, 0, 1, 1, 32'h1,  3'b001,  1, 1, 32'h1,  3'b001, 16'd0); // streaming
    add(1, 0, 1, 1, 32'h2,  3'b011,  1, 1, 32'h2,  3'b011, 16'd0);
    add(1, 0, 1, 1, 32'h3,  3'b101,  1, 1, 32'h3,  3'b101, 16'd0);
    add(1, 0, 1, 1, 32'h4,  3'b111,  1, 1, 32'h4,  3'b111, 16'd0);
    add(1, 0, 0, 1, 32'h0,  3'b000,  0, 1, 32'h4,  3'b000, 16'd0);
    add(1, 0, 1, 0, 32'hA,  3'b001,  1, 1, 32'hA,  3'b001, 16'd0); // backpressure
    add(1, 0, 1, 0, 32'hB,  3'b010,  1, 0, 32'hA,  3'b001, 16'd1);
    add(1, 0, 1, 0, 32'hC,  3'b100,  1, 0, 32'hA,  3'b001, 16'd2);
    add(1, 0, 1, 1, 32'hC,  3'b100,  1, 1, 32'hB,  3'b010, 16'd2);
    add(1, 0, 1, 1, 32'hC,  3'b100,  1, 1, 32'hC,  3'b100, 16'd2);
    add(1, 0, 0, 1, 32'h0,  3'b000,  0, 1, 32'hC,  3'b000, 16'd2);
    add(1, 0, 1, 0, 32'h11, 3'b111,  1, 1, 32'h11, 3'b111, 16'd2); // flush in TWO
    add(1, 0, 1, 0, 32'h12, 3'b110,  1, 0, 32'h11, 3'b111, 16'd3);
    add(1, 1, 1, 1, 32'hD,  3'b111,  0, 1, 32'h11, 3'b000, 16'd3);
    add(1, 0, 0, 1, 32'h0,  3'b000,  0, 1, 32'h11, 3'b000, 16'd3);
    add(1, 0, 1, 0, 32'h21, 3'b111,  1, 1, 32'h21, 3'b111, 16'd3); // reset in TWO
    add(1, 0, 1, 0, 32'h22, 3'b111,  1, 0, 32'h21, 3'b111, 16'd4);
    add(0, 0, 1, 1, 32'h23, 3'b111,  0, 1, 32'h0,  3'b000, 16'd0);
    add(1, 0, 1, 0, 32'h24, 3'b001,  1, 1, 32'h24, 3'b001, 16'd0); // accept right after reset
    add(1, 0, 0, 1, 32'h0,  3'b000,  0, 1, 32'h24, 3'b000, 16'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].valid_e, vecs[i].ready_m,
            vecs[i].instr_e, vecs[i].ctrl_e);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_validM", i), validM, vecs[i].exp_valid_m);
      check($sformatf("v%0d_readyE", i), readyE, vecs[i].exp_ready_e);
      check($sformatf("v%0d_instrM", i), instrM, vecs[i].exp_instr_m);
      check($sformatf("v%0d_ctrlM", i), ctrlM, vecs[i].exp_ctrl_m);
      check($sformatf("v%0d_stall", i), stall_cnt, vecs[i].exp_stall);
      check($sformatf("v%0d_aluoutM", i), aluoutM, alu_of(vecs[i].exp_instr_m));
      check($sformatf("v%0d_writedataM", i), writedataM, wd_of(vecs[i].exp_instr_m));
      check($sformatf("v%0d_writeregM", i), writeregM, vecs[i].exp_instr_m[4:0]);
    end

    // stall counter saturation on the CNT_W=4 copy
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h31, 3'b001);
    @(posedge clk);
    #1;
    check("sat_start", stall_cnt4, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 14) check("sat_14", stall_cnt4, 4'd14);
      if (k == 15) check("sat_15", stall_cnt4, 4'd15);
    end
    check("sat_hold", stall_cnt4, 4'd15);
    check("sat_wide", stall_cnt, 16'd20);
    check("sat_validM", validM, 1'b1);
    check("sat_instrM", instrM, 32'h31);
    readyM = 1'b1;
    @(posedge clk);
    #1;
    check("sat_drained", validM, 1'b0);
    check("sat_kept", stall_cnt4, 4'd15);

    // random 50% valid/ready with scoreboard
    exp_q.delete();
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      occ_prev = exp_q.size();
      rand_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      occ_prev = exp_q.size();
      rand_step(1'b0, 1'b1);
    end
    @(negedge clk);
    check("rnd_final_empty", validM, 1'b0);
    check("rnd_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/m_ex_mem_skid_reg.md
M_EX_MEM_SKID_REG -- requirements
Module: m_ex_mem_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ALU result and store data.
REQ-002 SHALL have parameter REG_W, default 5, width of destination register index.
REQ-003 SHALL have parameter INSTR_W, default 32, width of carried instruction word.
REQ-004 SHALL have parameter CTRL_W, default 3, width of control bundle, bit0=regwrite, bit1=memtoreg, bit2=memwrite.
REQ-005 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-006 clk  input  1  single clock; all state updates on posedge clk.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 flush  input  1  discard all held entries.
REQ-009 validE  input  1  EX stage presents a valid instruction.
REQ-010 readyE  output  1  block can accept from EX this cycle.
REQ-011 ctrlE  input  CTRL_W  control bundle from EX.
REQ-012 aluoutE  input  DATA_W  ALU result from EX.
REQ-013 writedataE  input  DATA_W  store data from EX.
REQ-014 writeregE  input  REG_W  destination register from EX.
REQ-015 instrE  input  INSTR_W  instruction word from EX.
REQ-016 validM  output  1  MEM-side entry valid.
REQ-017 readyM  input  1  MEM stage consumes entry this cycle.
REQ-018 ctrlM, aluoutM, writedataM, writeregM, instrM  output  widths as EX counterparts  head entry fields.
REQ-019 stall_cnt  output  CNT_W  cycles with validM=1 and readyM=0.

Function
REQ-020 SHALL hold two entries, main (drives M outputs) and skid; state EMPTY, ONE (main full), TWO (main and skid full).
REQ-021 readyE SHALL be a registered output equal to 1 in EMPTY and ONE, 0 in TWO; no combinational path from readyM to readyE.
REQ-022 Accept = validE & readyE; drain = validM & readyM.
REQ-023 EMPTY: accept -> ONE, main loaded; latency validE to validM is exactly 1 cycle.
REQ-024 ONE: accept & drain -> ONE, main replaced with new entry; accept & !drain -> TWO, new entry into skid; !accept & drain -> EMPTY; neither -> ONE, hold.
REQ-025 TWO: drain -> ONE, skid moves to main same edge; !drain -> TWO, hold; validE ignored (readyE=0).
REQ-026 Ordering SHALL be strict FIFO; no entry duplicated or lost except by flush/reset.
REQ-027 validM SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-028 ctrlM SHALL be all-zero whenever validM=0 (bubble carries no regwrite/memwrite); data outputs hold last value when invalid.
REQ-029 flush=1 SHALL, at the next edge, move to EMPTY, clear ctrl of both entries, set readyE=1; concurrent accept is dropped; flush overrides drain.
REQ-030 stall_cnt SHALL increment by 1 each cycle validM=1 & readyM=0, saturate at 2^CNT_W-1, not wrap; not cleared by flush.
REQ-031 Data widths SHALL pass through unmodified; no sign extension or truncation.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force EMPTY, validM=0, readyE=1, ctrlM=0, aluoutM=0, writedataM=0, writeregM=0, instrM=0, stall_cnt=0, skid entry zeroed.
REQ-033 Reset SHALL take priority over flush, accept and drain; asserted mid-transfer in TWO it discards both entries.
REQ-034 First accept SHALL be possible in the first cycle after rst_n returns to 1.

Verification
REQ-035 Streaming: readyM=1, 4 back-to-back valid entries instr 0x1..0x4 -> validM high cycles 1..4, instrM 0x1..0x4 in order, readyE stays 1, stall_cnt=0.
REQ-036 Backpressure: readyM=0, send instr 0xA, 0xB, 0xC -> TWO after 0xB, readyE=0, 0xC held at input; readyM=1 -> outputs 0xA, 0xB, 0xC in order, none lost.
REQ-037 Flush in TWO with validE=1 instr 0xD -> next cycle validM=0, ctrlM=0, readyE=1, 0xD never appears.
REQ-038 Reset mid-operation: TWO with ctrlM=3'b111, rst_n=0 one cycle -> all outputs zero, validM=0, stall_cnt=0, readyE=1.
REQ-039 Saturation with CNT_W=4: readyM=0 for 20 cycles with valid entry -> stall_cnt reaches 15 and holds.
REQ-040 Random valid/ready at 50% over 10000 cycles with scoreboard -> output sequence equals accepted sequence, ctrlM=0 on every cycle validM=0.
